// File: rtl/svm_mem_dma_resp_if.sv
// Request/response bundle between the DMA initiator and the memory responder.
// master drives requests and observes rdy/read data; slave is the responder side.
interface svm_mem_dma_resp_if;
    logic        mem_dma_req_vld;
    logic        mem_dma_rdbar_wr;
    logic [31:0] mem_dma_req_addr;
    logic [31:0] mem_dma_req_data;
    logic        mem_dma_rdy;
    logic [31:0] mem_dma_rd_data;
    logic        mem_dma_rd_data_vld;

    modport master (
        output mem_dma_req_vld,
        output mem_dma_rdbar_wr,
        output mem_dma_req_addr,
        output mem_dma_req_data,
        input  mem_dma_rdy,
        input  mem_dma_rd_data,
        input  mem_dma_rd_data_vld
    );

    modport slave (
        input  mem_dma_req_vld,
        input  mem_dma_rdbar_wr,
        input  mem_dma_req_addr,
        input  mem_dma_req_data,
        output mem_dma_rdy,
        output mem_dma_rd_data,
        output mem_dma_rd_data_vld
    );
endinterface

// File: rtl/svm_mem_dma_resp.sv
// SVM memory-DMA responder: request FIFO in front of a zero-initialised word SRAM.
// Ports: clk, rst_n, dma (slave bundle), err_clr_i, err_oob_o, err_cnt_o, init_done_o.
module svm_mem_dma_resp #(
    parameter int MEM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    svm_mem_dma_resp_if.slave    dma,
    input  logic                 err_clr_i,
    output logic                 err_oob_o,
    output logic [15:0]          err_cnt_o,
    output logic                 init_done_o
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_e;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] idx;
        logic [31:0]   data;
        logic          oob;
    } entry_t;

    state_e        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic          init_last;

    logic [31:0]   mem_q [MEM_WORDS];
    entry_t        fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          push, pop, rdy;
    entry_t        in_e, head;

    // Stage 0 is the SRAM read register; stages 1..RD_LAT follow it.
    logic          rd_vld_q  [RD_LAT+1];
    logic [31:0]   rd_data_q [RD_LAT+1];

    logic          err_oob_q;
    logic [15:0]   err_cnt_q;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^dma.mem_dma_req_addr[1:0];

    assign init_last  = (init_cnt_q == AW'(MEM_WORDS - 1));
    assign init_cnt_d = (state_q == S_INIT) ? init_cnt_q + 1'b1 : init_cnt_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:  if (init_last) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // Output logic; rdy depends on registered state only
    always_comb begin
        rdy         = 1'b0;
        init_done_o = 1'b0;
        if (state_q == S_RUN) begin
            rdy         = (cnt_q < (PW+1)'(FIFO_DEPTH));
            init_done_o = 1'b1;
        end
    end

    assign push = dma.mem_dma_req_vld && rdy;
    assign pop  = (cnt_q != '0);
    assign head = fifo_q[rd_ptr_q];

    always_comb begin
        in_e      = '0;
        in_e.wr   = dma.mem_dma_rdbar_wr;
        in_e.idx  = dma.mem_dma_req_addr[AW+1:2];
        in_e.data = dma.mem_dma_req_data;
        // addr[31:2] >= MEM_WORDS reduces to any bit above the index being set
        in_e.oob  = |dma.mem_dma_req_addr[31:AW+2];
    end

    assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

    // Storage without reset: FIFO slots and SRAM; INIT zeroes the SRAM
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= in_e;
        if (state_q == S_INIT)
            mem_q[init_cnt_q] <= '0;
        else if (pop && head.wr && !head.oob)
            mem_q[head.idx] <= head.data;
    end

    // State register and control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_oob_q  <= 1'b0;
            err_cnt_q  <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                rd_vld_q[k]  <= 1'b0;
                rd_data_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            cnt_q      <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            rd_vld_q[0] <= pop && !head.wr;
            if (pop && !head.wr)
                rd_data_q[0] <= head.oob ? 32'hDEAD_BEEF : mem_q[head.idx];
            // Data only advances with its valid so the output holds between reads
            for (int k = 1; k <= RD_LAT; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
                if (rd_vld_q[k-1])
                    rd_data_q[k] <= rd_data_q[k-1];
            end

            // Clear beats a coincident oob pop
            if (err_clr_i) begin
                err_oob_q <= 1'b0;
                err_cnt_q <= '0;
            end else if (pop && head.oob) begin
                err_oob_q <= 1'b1;
                if (err_cnt_q != 16'hFFFF)
                    err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign dma.mem_dma_rdy         = rdy;
    assign dma.mem_dma_rd_data     = rd_data_q[RD_LAT];
    assign dma.mem_dma_rd_data_vld = rd_vld_q[RD_LAT];
    assign err_oob_o               = err_oob_q;
    assign err_cnt_o               = err_cnt_q;
endmodule

// File: tb/tb_svm_mem_dma_resp.sv
// Directed bench for svm_mem_dma_resp with MEM_WORDS=16, FIFO_DEPTH=4, RD_LAT=2.
// Expected values are hand-computed constants; read data captured at negedge.
module tb_svm_mem_dma_resp;
    localparam int MW = 16;
    localparam int FD = 4;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr = 1'b0;
    logic        err_oob;
    logic [15:0] err_cnt;
    logic        init_done;

    svm_mem_dma_resp_if dma();

    svm_mem_dma_resp #(
        .MEM_WORDS (MW),
        .FIFO_DEPTH(FD),
        .RD_LAT    (RL)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dma        (dma),
        .err_clr_i  (err_clr),
        .err_oob_o  (err_oob),
        .err_cnt_o  (err_cnt),
        .init_done_o(init_done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] rq[$];
    int          rc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dma.mem_dma_rd_data_vld === 1'b1) begin
            rq.push_back(dma.mem_dma_rd_data);
            rc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [31:0] a,
                       input logic [31:0] d);
        dma.mem_dma_req_vld  = 1'b1;
        dma.mem_dma_rdbar_wr = w;
        dma.mem_dma_req_addr = a;
        dma.mem_dma_req_data = d;
        step();
        dma.mem_dma_req_vld  = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (dma.mem_dma_rdy !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    function automatic logic [31:0] rq_at(input int i);
        return (i < rq.size()) ? rq[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] rc_gap(input int i);
        return (i < rc.size()) ? 32'(rc[i] - rc[0]) : 32'hxxxx_xxxx;
    endfunction

    initial begin
        int   n;
        logic rdy_ok;
        dma.mem_dma_req_vld  = 1'b0;
        dma.mem_dma_rdbar_wr = 1'b0;
        dma.mem_dma_req_addr = '0;
        dma.mem_dma_req_data = '0;

        // Reset values
        repeat (3) step();
        chk("rst_rdy", 32'(dma.mem_dma_rdy), 0);
        chk("rst_rd_data", dma.mem_dma_rd_data, 0);
        chk("rst_rd_vld", 32'(dma.mem_dma_rd_data_vld), 0);
        chk("rst_err_oob", 32'(err_oob), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_init_done", 32'(init_done), 0);

        // INIT length
        rst_n = 1'b1;
        wait_init(n);
        chk("init_len", n, 16);
        chk("init_done", 32'(init_done), 1);

        // Read of last word after INIT is zero
        rq.delete(); rc.delete();
        req(1'b0, 32'h3C, 0);
        repeat (6) step();
        chk("rd3c_n", rq.size(), 1);
        chk("rd3c_data", rq_at(0), 0);

        // Write then read same address; exact latency
        req(1'b1, 32'h10, 32'hA5A5_0001);
        req(1'b0, 32'h10, 0);
        step(); step();
        chk("lat_vld_early", 32'(dma.mem_dma_rd_data_vld), 0);
        step();
        chk("lat_vld", 32'(dma.mem_dma_rd_data_vld), 1);
        chk("lat_data", dma.mem_dma_rd_data, 32'hA5A5_0001);
        repeat (3) step();

        // 8 writes then 8 back-to-back reads
        for (int i = 0; i < 8; i++) req(1'b1, 32'(4 * i), 32'(100 + i));
        rq.delete(); rc.delete();
        rdy_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (dma.mem_dma_rdy !== 1'b1) rdy_ok = 1'b0;
            req(1'b0, 32'(4 * i), 0);
        end
        repeat (6) step();
        chk("b2b_rdy", 32'(rdy_ok), 1);
        chk("b2b_n", rq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b_data%0d", i), rq_at(i), 32'(100 + i));
            chk($sformatf("b2b_gap%0d", i), rc_gap(i), 32'(i));
        end

        // Reset with reads in flight
        rq.delete(); rc.delete();
        req(1'b0, 32'h0, 0);
        req(1'b0, 32'h4, 0);
        req(1'b0, 32'h8, 0);
        step();
        chk("mid_vld_pre", 32'(dma.mem_dma_rd_data_vld), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_vld", 32'(dma.mem_dma_rd_data_vld), 0);
        chk("mid_data", dma.mem_dma_rd_data, 0);
        chk("mid_rdy", 32'(dma.mem_dma_rdy), 0);
        chk("mid_init_done", 32'(init_done), 0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_init(n);
        chk("reinit_len", n, 16);
        repeat (4) step();
        chk("no_stale", rq.size(), 0);
        req(1'b0, 32'h0, 0);
        repeat (6) step();
        chk("rezero_n", rq.size(), 1);
        chk("rezero_data", rq_at(0), 0);

        // Out-of-range accesses
        rq.delete(); rc.delete();
        chk("oob_cnt0", 32'(err_cnt), 0);
        req(1'b0, 32'h4000_0000, 0);
        req(1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
        repeat (6) step();
        chk("oob_rd_n", rq.size(), 1);
        chk("oob_rd_data", rq_at(0), 32'hDEAD_BEEF);
        chk("oob_flag", 32'(err_oob), 1);
        chk("oob_cnt", 32'(err_cnt), 2);
        req(1'b0, 32'h3C, 0);
        req(1'b0, 32'h0, 0);
        repeat (6) step();
        chk("oob_w15", rq_at(1), 0);
        chk("oob_w0", rq_at(2), 0);

        // err_clr on the pop edge of a third oob request
        req(1'b0, 32'h4000_0000, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_flag", 32'(err_oob), 0);
        chk("clr_cnt", 32'(err_cnt), 0);
        repeat (5) step();

        // Saturation
        rq.delete(); rc.delete();
        dma.mem_dma_req_vld  = 1'b1;
        dma.mem_dma_rdbar_wr = 1'b0;
        dma.mem_dma_req_addr = 32'h4000_0000;
        repeat (65540) step();
        dma.mem_dma_req_vld  = 1'b0;
        repeat (6) step();
        chk("sat_cnt", 32'(err_cnt), 32'hFFFF);
        chk("sat_flag", 32'(err_oob), 1);
        chk("sat_n", rq.size(), 65540);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/svm_mem_dma_resp.md
# svm_mem_dma_resp

Responder end of the SVM memory-DMA request interface. Accepts single-word read/write requests from `svm_mem_mngr` (`mem_dma_req_*` / `mem_dma_rdy`) into a small in-order request FIFO and services them against a local word-addressed SRAM model. Read data returns on `mem_dma_rd_data` / `mem_dma_rd_data_vld` after a fixed pipeline latency. Used as the on-chip weight/data/scratch store and as the bench memory for the SVM datapath.

## Interface
- `MEM_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, ≥ 2.
- `RD_LAT`, 2: read pipeline stages after FIFO pop; ≥ 1.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mem_dma_req_vld` in 1: request valid.
- `mem_dma_rdbar_wr` in 1: 0 = read, 1 = write.
- `mem_dma_req_addr` in 32: byte address; bits [1:0] ignored.
- `mem_dma_req_data` in 32: write data.
- `mem_dma_rdy` out 1: request accepted on an edge where `vld && rdy`.
- `mem_dma_rd_data` out 32: read data.
- `mem_dma_rd_data_vld` out 1: one-cycle pulse per read; no backpressure.
- `err_clr` in 1: synchronous clear of the error flag and counter.
- `err_oob` out 1: sticky out-of-range flag.
- `err_cnt` out 16: saturating count of out-of-range requests.
- `init_done` out 1: high once memory clear completes.

## Operation
- FSM states:
  - INIT: entered on reset. A word counter clears one word to 0 per cycle, words 0..MEM_WORDS-1. The FSM moves to RUN on the edge that clears the last word. `mem_dma_rdy` = 0 throughout INIT.
  - RUN: terminal state; only reset leaves it.
- `init_done` = 1 in RUN.
- `mem_dma_rdy` = (state == RUN) && (fifo_count < FIFO_DEPTH). It is combinational from registered state and never depends on `mem_dma_req_vld`.
- Accept: the FIFO pushes {rdbar_wr, word index, data, oob}.
  - Word index = addr[log2(MEM_WORDS)+1:2].
  - oob = (addr[31:2] ≥ MEM_WORDS).
- Service: when the FIFO is non-empty it pops exactly one entry per cycle. Requests are serviced strictly in acceptance order.
- Write entry: the memory word is updated at the pop edge. If oob, the write is dropped.
- Read entry: memory is read at the pop edge. {valid, data} then shifts through RD_LAT register stages. If oob, the data is forced to 32'hDEAD_BEEF.
- Ordering: a read popped after a write to the same index returns the new data.
- Push and pop in the same cycle: count is unchanged. The FIFO pointers wrap modulo FIFO_DEPTH.
- Errors: each oob entry sets `err_oob` and increments `err_cnt` at its pop edge. `err_cnt` saturates at 16'hFFFF.
  - If `err_clr` and an oob pop fall on the same edge, `err_clr` wins and the result is flag 0, count 0.
- Reset while operating (asynchronous) discards all of the following and restarts INIT:
  - FIFO contents and pointers
  - in-flight reads
  - the error state
- Memory contents are not held across reset. INIT re-zeroes them.

## Timing
- Reset values:
  - `mem_dma_rdy` 0
  - `mem_dma_rd_data` 32'h0
  - `mem_dma_rd_data_vld` 0
  - `err_oob` 0
  - `err_cnt` 0
  - `init_done` 0
- INIT lasts exactly MEM_WORDS cycles after reset release. `mem_dma_rdy` first rises in the cycle after the last clear edge.
- Read latency with an empty FIFO: a read accepted at edge N is popped at edge N+1. `mem_dma_rd_data_vld` = 1 with valid data in the cycle between edges N+1+RD_LAT and N+2+RD_LAT. With RD_LAT = 2, that data is sampled by the initiator at edge N+4.
- A write accepted at edge N commits at edge N+1 (empty FIFO).
- Throughput: 1 request per cycle sustained. FIFO count never exceeds 1 under steady back-to-back traffic.
- `mem_dma_rd_data` holds its last value when `mem_dma_rd_data_vld` = 0.

## Test plan
- Reset release, MEM_WORDS = 16 → `mem_dma_rdy` = 0 for 16 cycles then 1, `init_done` = 1. A read of addr 0x3C returns 0.
- Write 0xA5A5_0001 to addr 0x10 at edge N, read addr 0x10 at edge N+1 → rd_data = 0xA5A5_0001 with vld sampled at edge N+5 (RD_LAT = 2).
- 8 back-to-back reads of addrs 0x0..0x1C after writing the values i+100 → 8 consecutive vld pulses returning 100..107 in order. `mem_dma_rdy` never drops.
- Hold the pop stage by issuing reads faster than one per cycle is impossible; instead assert reset mid-burst (3 reads in flight) → vld = 0 immediately, no stale data after release, INIT repeats.
- Read addr 0x4000_0000 and write addr 0xFFFF_FFFC → read returns 0xDEAD_BEEF, no memory word changes, `err_oob` = 1, `err_cnt` = 2. Asserting `err_clr` on the edge of a third oob pop → flag 0, count 0.
- Force `err_cnt` to saturation via 65,540 oob reads → `err_cnt` = 0xFFFF, no wrap.
